// File: rtl/clk_gen.sv
// clk_gen: programmable 50%-duty clock divider with rise/fall tick strobes and a period counter.
// Optional CLK_GATE_EN adds a hold input that parks clk_out low between periods.
module clk_gen #(
  parameter int unsigned DIV_WIDTH   = 8,
  parameter int unsigned DEFAULT_DIV = 4,
  parameter int unsigned PCNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [DIV_WIDTH-1:0]  div,
`ifdef CLK_GATE_EN
  input  logic                  hold,
`endif
  output logic                  clk_out,
  output logic                  rise_tick,
  output logic                  fall_tick,
  output logic                  cfg_pending,
  output logic [PCNT_WIDTH-1:0] periods
);

  logic [DIV_WIDTH-1:0]  r_cnt;
  logic [DIV_WIDTH-1:0]  r_div_q;
  logic [DIV_WIDTH-1:0]  r_div_pend;
  logic                  r_pend;
  logic                  r_clk_out;
  logic                  r_rise;
  logic                  r_fall;
  logic [PCNT_WIDTH-1:0] r_periods;

  logic w_wrap;
  logic w_freeze;

  assign w_wrap = (r_cnt == r_div_q);

`ifdef CLK_GATE_EN
  // The high phase always runs to completion; hold only parks the low phase.
  assign w_freeze = hold & ~r_clk_out;
`else
  assign w_freeze = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_div_q    <= DIV_WIDTH'(DEFAULT_DIV);
      r_div_pend <= '0;
      r_pend     <= 1'b0;
      r_clk_out  <= 1'b0;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
      r_periods  <= '0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (en) begin
        if (w_freeze) begin
          // Restart the low phase so release yields a full div_q+1 low half-period.
          r_cnt <= '0;
        end else if (w_wrap) begin
          r_cnt     <= '0;
          r_clk_out <= ~r_clk_out;
          if (!r_clk_out) begin
            r_rise    <= 1'b1;
            r_periods <= r_periods + 1'b1;
            if (r_pend) begin
              r_div_q <= r_div_pend;
              r_pend  <= 1'b0;
            end
          end else begin
            r_fall <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        // A load coinciding with a rise becomes pending for the following period.
        if (load) begin
          r_div_pend <= div;
          r_pend     <= 1'b1;
        end
      end else if (load) begin
        r_div_q <= div;
        r_cnt   <= '0;
      end
    end
  end

  assign clk_out     = r_clk_out;
  assign rise_tick   = r_rise;
  assign fall_tick   = r_fall;
  assign cfg_pending = r_pend;
  assign periods     = r_periods;

endmodule

// File: tb/tb_clk_gen.sv
// tb_clk_gen: scoreboard bench for clk_gen; an event-level model predicts every cycle's outputs.
module tb_clk_gen;
  localparam int DEF = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        load = 1'b0;
  logic [7:0]  div = 8'd0;
  logic        co, rt, ft, cp;
  logic [15:0] per;
  logic        co4, rt4, ft4, cp4;
  logic [3:0]  per4;

  always #5 clk = ~clk;

  clk_gen #(.DIV_WIDTH(8), .DEFAULT_DIV(DEF), .PCNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .div(div),
`ifdef CLK_GATE_EN
    .hold(1'b0),
`endif
    .clk_out(co), .rise_tick(rt), .fall_tick(ft), .cfg_pending(cp), .periods(per)
  );

  clk_gen #(.DIV_WIDTH(8), .DEFAULT_DIV(DEF), .PCNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .load(load), .div(div),
`ifdef CLK_GATE_EN
    .hold(1'b0),
`endif
    .clk_out(co4), .rise_tick(rt4), .fall_tick(ft4), .cfg_pending(cp4), .periods(per4)
  );

  typedef struct packed {
    logic        lvl;
    logic        rise;
    logic        fall;
    logic        pend;
    logic [15:0] per;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  // Model state: active cycles left until the next toggle, divisor in force, pending divisor.
  int          m_rem = DEF + 1;
  int          m_div = DEF;
  int          m_pval = 0;
  bit          m_pv = 1'b0;
  bit          m_lvl = 1'b0;
  logic [15:0] m_per = 16'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic l, input logic [7:0] d);
    exp_t x;
    bit   rise, fall;
    @(negedge clk);
    rst  = r;
    en   = e;
    load = l;
    div  = d;
    rise = 1'b0;
    fall = 1'b0;
    if (!r) begin
      m_lvl = 1'b0; m_rem = DEF + 1; m_div = DEF; m_pv = 1'b0; m_per = 16'd0;
    end else if (e) begin
      m_rem--;
      if (m_rem == 0) begin
        m_lvl = !m_lvl;
        if (m_lvl) begin
          rise  = 1'b1;
          m_per = m_per + 16'd1;
          if (m_pv) begin
            m_div = m_pval;
            m_pv  = 1'b0;
          end
        end else begin
          fall = 1'b1;
        end
        m_rem = m_div + 1;
      end
      if (l) begin
        m_pv   = 1'b1;
        m_pval = int'(d);
      end
    end else if (l) begin
      m_div = int'(d);
      m_rem = m_div + 1;
    end
    x.lvl  = m_lvl;
    x.rise = rise;
    x.fall = fall;
    x.pend = m_pv;
    x.per  = m_per;
    q.push_back(x);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("clk_out", 32'(co), 32'(e.lvl));
        chk("rise_tick", 32'(rt), 32'(e.rise));
        chk("fall_tick", 32'(ft), 32'(e.fall));
        chk("cfg_pending", 32'(cp), 32'(e.pend));
        chk("periods", 32'(per), 32'(e.per));
        chk("clk_out_w4", 32'(co4), 32'(e.lvl));
        chk("periods_w4", 32'(per4), 32'(e.per[3:0]));
      end
    end
  end

  initial begin
    logic [7:0] d;
    repeat (2) step(1'b0, 1'b0, 1'b0, 8'd0);
    // Default divisor: rises 5 cycles after release, periods reaches 3 after 30 cycles.
    repeat (30) step(1'b1, 1'b1, 1'b0, 8'd0);
    // div=0 applied at the next rise, then clk/2.
    step(1'b1, 1'b1, 1'b1, 8'd0);
    repeat (20) step(1'b1, 1'b1, 1'b0, 8'd0);
    // Last-load-wins: 2 is overwritten by 7 before the boundary.
    step(1'b1, 1'b1, 1'b1, 8'd5);
    repeat (15) step(1'b1, 1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b1, 8'd2);
    repeat (2) step(1'b1, 1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 1'b1, 8'd7);
    repeat (40) step(1'b1, 1'b1, 1'b0, 8'd0);
    // Enable gap mid-phase.
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'd0);
    repeat (6) step(1'b1, 1'b0, 1'b0, 8'd0);
    repeat (20) step(1'b1, 1'b1, 1'b0, 8'd0);
    // Reset with a load pending discards it.
    step(1'b1, 1'b1, 1'b1, 8'd9);
    step(1'b1, 1'b1, 1'b0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 8'd0);
    repeat (12) step(1'b1, 1'b1, 1'b0, 8'd0);
    // Load while disabled takes effect immediately.
    step(1'b1, 1'b0, 1'b1, 8'd3);
    repeat (20) step(1'b1, 1'b1, 1'b0, 8'd0);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      d = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      step(($urandom_range(0, 299) != 0), ($urandom_range(0, 7) != 0),
           ($urandom_range(0, 9) == 0), d);
    end
    // 16 default periods: the 4-bit counter wraps to 0 on the 16th rise.
    step(1'b0, 1'b0, 1'b0, 8'd0);
    repeat (160) step(1'b1, 1'b1, 1'b0, 8'd0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/clk_gen.md
Name: clk_gen

Overview:
- Programmable clock-divider and tick generator driven by the single system clock.
- Produces a 50%-duty divided clock level, one-cycle rise/fall tick strobes and a count of completed output periods.
- Serves as the timing source for counter/game logic, for example the game counter that advances once per divided period.
- Fully synchronous: no derived clock is used as a clock inside this block.

Parameters:
- DIV_WIDTH, 8, width of the half-period divisor.
- DEFAULT_DIV, 4, divisor loaded at reset. The half-period is DEFAULT_DIV+1 cycles, so the default output period is 10 clk cycles.
- PCNT_WIDTH, 16, width of the completed-period counter.

Ports:
- clk  input  1  system clock; all logic updates on its rising edge.
- rst  input  1  reset, synchronous, active-low.
- en  input  1  run enable; when 0, all state holds.
- load  input  1  one-cycle request to take a new divisor from div.
- div  input  DIV_WIDTH  new half-period divisor; each half-period is div+1 clk cycles.
- clk_out  output  1  divided clock level, registered.
- rise_tick  output  1  one-cycle pulse, high in the same cycle clk_out first reads 1.
- fall_tick  output  1  one-cycle pulse, high in the same cycle clk_out first reads 0.
- cfg_pending  output  1  a loaded divisor is waiting to be applied.
- periods  output  PCNT_WIDTH  number of rising toggles since reset; wraps around.

Behaviour:
- Reset (rst==0 at a clk edge): cnt=0, div_q=DEFAULT_DIV, div_pend=0, clk_out=0, rise_tick=0, fall_tick=0, cfg_pending=0, periods=0. Reset takes priority over every other input.
- Ticks default to 0 every cycle; each tick is high for exactly one cycle.
- en=1 and cnt!=div_q: cnt<=cnt+1.
- en=1 and cnt==div_q: cnt<=0 and clk_out<=~clk_out.
  - On a 0->1 toggle: rise_tick<=1 and periods<=periods+1, wrapping modulo 2^PCNT_WIDTH.
  - On a 1->0 toggle: fall_tick<=1.
- Output timing: period = 2*(div_q+1) cycles, duty exactly 50%.
  - div_q=0 gives clk/2 and a tick every cycle, alternating rise and fall.
  - The first rise_tick after reset with en held at 1 occurs DEFAULT_DIV+1 cycles after rst deasserts.
- en=0: cnt, clk_out and periods hold; no ticks.
- load=1 with en=1:
  - div_pend<=div and cfg_pending<=1.
  - The pending value is applied to div_q on the next 0->1 toggle, i.e. the start of a new period. In that same cycle cfg_pending<=0.
  - The current period always completes with the old divisor, so no shortened half-period is produced.
- load=1 with en=0: div_q<=div immediately, cnt<=0, cfg_pending stays 0, and clk_out holds its level.
- load while cfg_pending=1: the newer value overwrites div_pend; only the last value is applied.
- load in the same cycle as a 0->1 toggle: the old div_pend (if pending) is applied now. The new value becomes pending for the following period.
- Divisor range is 0..2^DIV_WIDTH-1; all values are legal.
- Reset mid-operation: all state returns to reset values on that edge, and any pending divisor is discarded.

Optional Feature:
- CLK_GATE_EN defined: adds input port hold (1 bit).
  - hold=1 while clk_out=1: the high phase completes normally (fall_tick still fires). The counter then freezes at 0 with clk_out=0, and no rise_tick is produced while hold=1.
  - hold=1 while clk_out=0: the counter freezes immediately.
  - On release (hold=0), a full low half-period of div_q+1 cycles elapses before the next rise_tick.
  - A pending divisor is applied at that next rise.
- CLK_GATE_EN undefined: no hold port; behaviour is exactly as above.

Test Plan:
- Reset then en=1, default divisor -> first rise_tick 5 cycles after release; clk_out toggles every 5 cycles; periods=3 after 30 cycles.
- en=1, load div=0 -> applied at the next rise; thereafter clk_out toggles every cycle and rise_tick/fall_tick alternate each cycle.
- Mid-high-phase load div=2, then load div=7 before the boundary -> cfg_pending=1 until the next rise; the old half-period completes; new half-period is 8 cycles; the value 2 is never used.
- Toggle en low for 6 cycles mid-phase -> clk_out, cnt and periods are frozen and no ticks occur; the phase resumes exactly where it stopped.
- Assert rst=0 for one cycle mid-period with a load pending -> next cycle clk_out=0, periods=0, cfg_pending=0, div_q=4.
- PCNT_WIDTH=4, run 16 periods -> periods wraps to 0 on the 16th rise_tick.
